// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the fetch PC, issues imem requests, buffers in-order responses
// and presents them through a registered IF/ID stage. Define IF_MISALIGN_CHECK_EN to trap misaligned redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        valid_id,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        misalign_id
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]    fetch_pc;
  logic [PW-1:0]  alloc_ptr, fill_ptr, read_ptr, drop_cnt;
  logic [DEPTH-1:0] filled;
  logic [31:0]    ent_pc   [DEPTH];
  logic [31:0]    ent_inst [DEPTH];

  logic [AW-1:0]  ai, fi, ri;
  logic [PW-1:0]  allocated, unfilled, credit_use, outstanding, drop_next;
  logic           accept, rsp_fill, head_avail, can_load, pop;
  logic [31:0]    head_inst, target;
  logic           halted;

`ifdef IF_MISALIGN_CHECK_EN
  logic misaligned, misalign_pending;
  assign misaligned = (redirect_addr[1:0] != 2'b00);
  assign target     = redirect_addr;
`else
  assign halted = 1'b0;
  assign target = redirect_addr & ~32'h0000_0003;
`endif

  assign ai = alloc_ptr[AW-1:0];
  assign fi = fill_ptr[AW-1:0];
  assign ri = read_ptr[AW-1:0];

  // Pointers carry one wrap bit, so plain differences give occupancy up to DEPTH.
  always_comb begin
    allocated      = alloc_ptr - read_ptr;
    unfilled       = alloc_ptr - fill_ptr;
    credit_use     = allocated + drop_cnt;
    imem_req_valid = clk_en & ~redirect & ~halted & (credit_use < PW'(DEPTH));
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid & imem_req_ready;
    rsp_fill       = clk_en & ~redirect & imem_rsp_valid & (drop_cnt == '0);
    // A response for the head entry bypasses straight into IF/ID to keep one instruction per cycle.
    head_avail     = filled[ri] | (rsp_fill & (fill_ptr == read_ptr));
    head_inst      = filled[ri] ? ent_inst[ri] : imem_rsp_data;
    can_load       = ~valid_id | ~stall;
    pop            = can_load & head_avail;
    outstanding    = unfilled + drop_cnt;
    drop_next      = outstanding;
    if (imem_rsp_valid && (outstanding != '0))
      drop_next = outstanding - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (clk_en && !redirect) begin
      if (accept)
        ent_pc[ai] <= fetch_pc;
      if (rsp_fill)
        ent_inst[fi] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
      valid_id  <= 1'b0;
      inst_id   <= NOP;
      pc_id     <= '0;
`ifdef IF_MISALIGN_CHECK_EN
      halted           <= 1'b0;
      misalign_pending <= 1'b0;
      misalign_id      <= 1'b0;
`endif
    end else if (clk_en) begin
      if (redirect) begin
        fetch_pc  <= target;
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        read_ptr  <= '0;
        filled    <= '0;
        drop_cnt  <= drop_next;
        valid_id  <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        halted           <= misaligned;
        misalign_pending <= misaligned;
        misalign_id      <= 1'b0;
`endif
      end else begin
        if (accept) begin
          fetch_pc      <= fetch_pc + 32'd4;
          alloc_ptr     <= alloc_ptr + PW'(1);
          filled[ai]    <= 1'b0;
        end
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - PW'(1);
          end else begin
            filled[fi] <= 1'b1;
            fill_ptr   <= fill_ptr + PW'(1);
          end
        end
`ifdef IF_MISALIGN_CHECK_EN
        // fetch_pc still holds the faulting target while halted.
        if (misalign_pending) begin
          if (can_load) begin
            valid_id         <= 1'b1;
            misalign_id      <= 1'b1;
            inst_id          <= NOP;
            pc_id            <= fetch_pc;
            misalign_pending <= 1'b0;
          end
        end else
`endif
        if (pop) begin
          valid_id   <= 1'b1;
          inst_id    <= head_inst;
          pc_id      <= ent_pc[ri];
          filled[ri] <= 1'b0;
          read_ptr   <= read_ptr + PW'(1);
`ifdef IF_MISALIGN_CHECK_EN
          misalign_id <= 1'b0;
`endif
        end else if (!stall) begin
          valid_id <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
          misalign_id <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a latency-configurable memory model feeds the DUT,
// accepted fetch PCs are queued as expectations and popped as decode consumes IF/ID.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect, stall;
  logic [31:0] redirect_addr;
  logic        valid_id;
  logic [31:0] inst_id, pc_id;
`ifdef IF_MISALIGN_CHECK_EN
  logic        misalign_id;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_addr(redirect_addr), .stall(stall),
    .valid_id(valid_id), .inst_id(inst_id), .pc_id(pc_id)
`ifdef IF_MISALIGN_CHECK_EN
    , .misalign_id(misalign_id)
`endif
  );

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          assertions = 0;
  int          failures   = 0;
  int unsigned cyc, lat, last_due;
  logic [31:0] model_pc;
  logic        s_req, s_acc, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;
`ifdef IF_MISALIGN_CHECK_EN
  logic        s_mis, halted_m, mis_expect;
  logic [31:0] mis_pc;
`endif

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0F0F;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    mreq_t m;
    logic [31:0] e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (clk_en && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(m.addr);
    end
    #1;
    s_req = imem_req_valid; s_addr = imem_req_addr;
    s_valid = valid_id; s_pc = pc_id; s_inst = inst_id;
    s_acc = clk_en & imem_req_valid & imem_req_ready;
`ifdef IF_MISALIGN_CHECK_EN
    s_mis = misalign_id;
`endif
    if (s_acc) begin
      assertions++;
`ifdef IF_MISALIGN_CHECK_EN
      if (imem_req_addr !== model_pc || halted_m) begin
`else
      if (imem_req_addr !== model_pc) begin
`endif
        failures++;
        $display("FAIL req_addr: got %h expected %h (cycle %0d)", imem_req_addr, model_pc, cyc);
      end
      m.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = m.due;
      m.addr = imem_req_addr;
      mem_q.push_back(m);
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    if (clk_en && valid_id && !stall && !redirect) begin
      assertions++;
`ifdef IF_MISALIGN_CHECK_EN
      if (misalign_id) begin
        if (!mis_expect || pc_id !== mis_pc || inst_id !== NOP) begin
          failures++;
          $display("FAIL sb_misalign: got pc %h inst %h expected pc %h inst %h", pc_id, inst_id, mis_pc, NOP);
        end
        mis_expect = 1'b0;
      end else
`endif
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc %h expected no instruction", pc_id);
      end else begin
        e = exp_q.pop_front();
        if (pc_id !== e || inst_id !== inst_of(e)) begin
          failures++;
          $display("FAIL sb_order: got pc %h inst %h expected pc %h inst %h", pc_id, inst_id, e, inst_of(e));
        end
      end
    end
    if (clk_en && redirect) begin
      exp_q.delete();
`ifdef IF_MISALIGN_CHECK_EN
      model_pc   = redirect_addr;
      halted_m   = (redirect_addr[1:0] != 2'b00);
      mis_expect = halted_m;
      mis_pc     = redirect_addr;
`else
      model_pc = redirect_addr & ~32'h0000_0003;
`endif
    end
    @(posedge clk);
    @(negedge clk);
    if (clk_en) cyc++;
  endtask

  task automatic do_reset(input int unsigned l);
    rst = 1'b1; clk_en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    mem_q.delete(); exp_q.delete();
    cyc = 0; last_due = 0; lat = l; model_pc = 32'h0000_0100;
`ifdef IF_MISALIGN_CHECK_EN
    halted_m = 1'b0; mis_expect = 1'b0; mis_pc = '0;
`endif
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    assertions++;
    if (valid_id !== 1'b0 || inst_id !== NOP || pc_id !== 32'h0) begin
      failures++;
      $display("FAIL reset_ifid: got v=%b inst=%h pc=%h expected v=0 inst=%h pc=0", valid_id, inst_id, pc_id, NOP);
    end
    assertions++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL reset_req: got v=%b addr=%h expected v=1 addr=00000100", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want [3];
    want[0] = 32'h100; want[1] = 32'h104; want[2] = 32'h108;
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions++;
      if (!s_acc || s_addr !== want[i]) begin
        failures++;
        $display("FAIL stream_req%0d: got acc=%b addr=%h expected acc=1 addr=%h", i, s_acc, s_addr, want[i]);
      end
      assertions++;
      if (s_valid !== (i == 2) || (i == 2 && s_pc !== 32'h100)) begin
        failures++;
        $display("FAIL stream_valid%0d: got v=%b pc=%h expected v=%0d pc=00000100", i, s_valid, s_pc, i == 2);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      assertions++;
      if (s_valid !== 1'b1) begin
        failures++;
        $display("FAIL throughput: got valid_id %b expected 1 (cycle %0d)", s_valid, cyc);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p, n;
    stall = 1'b1;
    tick();
    p = s_pc; n = s_inst;
    assertions++;
    if (s_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_valid: got %b expected 1", s_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      assertions++;
      if (s_valid !== 1'b1 || s_pc !== p || s_inst !== n) begin
        failures++;
        $display("FAIL stall_hold: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", s_valid, s_pc, s_inst, p, n);
      end
      assertions++;
      if (s_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_full: got imem_req_valid %b expected 0", s_req);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_redirect_rsp_stall();
    stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h400;
    tick();
    assertions++;
    if (s_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_no_req: got imem_req_valid %b expected 0", s_req);
    end
    stall = 1'b0; redirect = 1'b0;
    tick();
    assertions++;
    if (s_valid !== 1'b0 || !s_acc || s_addr !== 32'h400) begin
      failures++;
      $display("FAIL redir_r1: got v=%b acc=%b addr=%h expected v=0 acc=1 addr=00000400", s_valid, s_acc, s_addr);
    end
    tick();
    tick();
    assertions++;
    if (s_valid !== 1'b1 || s_pc !== 32'h400) begin
      failures++;
      $display("FAIL redir_r3: got v=%b pc=%h expected v=1 pc=00000400", s_valid, s_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions++;
      if (!s_acc || s_addr !== want[i]) begin
        failures++;
        $display("FAIL wrap_req%0d: got acc=%b addr=%h expected acc=1 addr=%h", i, s_acc, s_addr, want[i]);
      end
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_addr = 32'h202;
    tick();
    redirect = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    tick();
    assertions++;
    if (s_req !== 1'b0) begin
      failures++;
      $display("FAIL halt_no_req: got imem_req_valid %b expected 0", s_req);
    end
    tick();
    assertions++;
    if (s_valid !== 1'b1 || s_mis !== 1'b1 || s_pc !== 32'h202 || s_inst !== NOP) begin
      failures++;
      $display("FAIL misalign_present: got v=%b mis=%b pc=%h inst=%h expected 1 1 00000202 %h", s_valid, s_mis, s_pc, s_inst, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions++;
      if (s_req !== 1'b0 || s_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_idle: got req=%b v=%b expected 0 0", s_req, s_valid);
      end
    end
    redirect = 1'b1; redirect_addr = 32'h300;
    tick();
    redirect = 1'b0;
    tick();
    assertions++;
    if (!s_acc || s_addr !== 32'h300) begin
      failures++;
      $display("FAIL halt_resume: got acc=%b addr=%h expected acc=1 addr=00000300", s_acc, s_addr);
    end
    tick();
    tick();
    assertions++;
    if (s_valid !== 1'b1 || s_pc !== 32'h300 || s_mis !== 1'b0) begin
      failures++;
      $display("FAIL resume_valid: got v=%b pc=%h mis=%b expected 1 00000300 0", s_valid, s_pc, s_mis);
    end
`else
    tick();
    assertions++;
    if (!s_acc || s_addr !== 32'h200) begin
      failures++;
      $display("FAIL align_force: got acc=%b addr=%h expected acc=1 addr=00000200", s_acc, s_addr);
    end
    tick();
    tick();
    assertions++;
    if (s_valid !== 1'b1 || s_pc !== 32'h200) begin
      failures++;
      $display("FAIL align_valid: got v=%b pc=%h expected v=1 pc=00000200", s_valid, s_pc);
    end
`endif
  endtask

  task automatic test_redirect_drop();
    bit seen;
    do_reset(3);
    tick();
    tick();
    redirect = 1'b1; redirect_addr = 32'h200;
    tick();
    redirect = 1'b0;
    tick();
    assertions++;
    if (s_req !== 1'b0) begin
      failures++;
      $display("FAIL drop_credit: got imem_req_valid %b expected 0", s_req);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (s_valid) begin
        seen = 1'b1;
        assertions++;
        if (s_pc !== 32'h200) begin
          failures++;
          $display("FAIL drop_first: got pc %h expected 00000200", s_pc);
        end
      end
    end
    if (!seen) begin
      assertions++;
      failures++;
      $display("FAIL drop_timeout: got no valid_id expected pc 00000200");
    end
  endtask

  task automatic test_clk_en();
    logic [31:0] p;
    logic v;
    do_reset(1);
    for (int i = 0; i < 5; i++) tick();
    clk_en = 1'b0;
    tick();
    p = s_pc; v = s_valid;
    for (int i = 0; i < 2; i++) begin
      tick();
      assertions++;
      if (s_req !== 1'b0 || s_pc !== p || s_valid !== v) begin
        failures++;
        $display("FAIL clken_hold: got req=%b v=%b pc=%h expected req=0 v=%b pc=%h", s_req, s_valid, s_pc, v, p);
      end
    end
    clk_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_drain();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending instructions expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_rsp_stall();
    test_wrap();
    test_misalign();
    test_redirect_drop();
    test_clk_en();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the riscv-small pipeline. It owns the fetch PC and issues requests to instruction memory over a valid/ready handshake. Returned words are held in a small in-order buffer, and each instruction is presented with its PC to the instruction decode stage through a registered IF/ID output. It honours decode-stage stalls and redirects from the jump decision unit, flushing any wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, in-flight plus buffered entries; power of two, at least 2

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  clock enable; while low, all state holds and imem_req_valid=0
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word aligned
- imem_req_ready  in  1  memory accepts the request
- imem_rsp_valid  in  1  response valid; responses are in order, latency ≥1, and cannot be back-pressured
- imem_rsp_data  in  32  instruction word
- redirect  in  1  jump decision says the branch is taken; flush and refetch
- redirect_addr  in  32  jump target (jump_addr)
- stall  in  1  decode stage cannot accept; hold the IF/ID register
- valid_id  out  1  inst_id and pc_id are valid
- inst_id  out  32  instruction to decode
- pc_id  out  32  PC of inst_id
- misalign_id  out  1  misaligned jump target; exists only when IF_MISALIGN_CHECK_EN is defined

## Operation
- **Entry ring.** DEPTH entries, each {pc, inst, filled}, managed by three pointers: alloc, fill and read. An entry is allocated on request acceptance, filled on response and freed when it moves into the IF/ID register.
- **Credit rule.** imem_req_valid = clk_en & ~redirect & ~halted & (allocated + drop_cnt < DEPTH). imem_req_addr = fetch_pc.
- **Request accept.** On imem_req_valid & imem_req_ready: fetch_pc <= fetch_pc + 4, wrapping modulo 2^32. The entry stores the request PC.
- **Response.** If drop_cnt>0, the response is discarded and drop_cnt decrements. Otherwise the entry at the fill pointer is written and marked filled.
- **IF/ID load.** The register loads when (~valid_id | ~stall) and the head entry is filled. If it loads nothing while ~stall, valid_id <= 0.
- **Redirect** has priority over all other events in its cycle:
  - fetch_pc <= redirect_addr; all entries are freed; valid_id <= 0.
  - drop_cnt <= outstanding − (imem_rsp_valid ? 1 : 0), where outstanding = allocated but not yet filled entries plus the current drop_cnt. A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
- **Stall** holds inst_id, pc_id and valid_id unchanged. Fetching continues until credits run out.
- **Reset values:**
  - valid_id=0, inst_id=32'h0000_0013 (NOP), pc_id=0
  - fetch_pc=RESET_PC, pointers=0, drop_cnt=0, halted=0, misalign_id=0
  - Reset mid-operation abandons all in-flight responses. The memory shares rst and is reset with the block.

## Timing
- Request accepted in cycle N with a 1-cycle memory: response in N+1, valid_id high in N+2.
- With DEPTH=2 and a 1-cycle memory, sustained throughput is one instruction per cycle.
- Redirect in cycle R: first request to redirect_addr in R+1; its instruction is valid at R+3 or later.
- imem_rsp_valid is sampled only when clk_en=1. The memory is gated by the same clk_en.
- Full: allocated + drop_cnt = DEPTH, so imem_req_valid=0.
- Empty: no filled head entry, so valid_id drops the cycle after a non-stalled pop.

## Configuration
- **IF_MISALIGN_CHECK_EN defined:**
  - A redirect with redirect_addr[1:0] ≠ 0 sets halted=1 and stops all requests.
  - The next IF/ID load presents valid_id=1, misalign_id=1, pc_id=redirect_addr, inst_id=NOP. This is held under stall and then followed by bubbles.
  - halted clears only on a later redirect or on reset.
- **Not defined:** redirect_addr[1:0] is forced to 2'b00 and the misalign_id port is absent.

## Test plan
- Reset with RESET_PC=32'h100, 1-cycle memory, no stall → requests 0x100, 0x104, 0x108 on consecutive cycles; valid_id from cycle 2 with pc_id 0x100, 0x104, …
- stall held for 3 cycles → inst_id/pc_id stable; imem_req_valid drops once allocated=2; resumes without loss or duplication.
- redirect to 0x200 while 2 fetches are outstanding on a 3-cycle memory → both stale responses dropped; next valid pc_id=0x200.
- redirect together with imem_rsp_valid and stall in the same cycle → response discarded, valid_id=0 next cycle, no request issued that cycle.
- fetch_pc=32'hFFFF_FFFC → next request address 32'h0000_0000.
- IF_MISALIGN_CHECK_EN defined, redirect to 0x202 → misalign_id=1 with pc_id=0x202, then no requests; redirect to 0x300 resumes fetching.
